ex_stage_pipe: RTL and testbench
================================

Name: ex_stage_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle execute stage.
- Accepts one decoded op per valid/ready handshake and registers the result into an output (EX/MEM) holding register.
- Resolves branches and jumps with a one-cycle registered redirect pulse.
- Adds an iterative multi-cycle multiplier with back-pressure and a synchronous flush.

Parameters:
- WIDTH, 16, datapath width in bits; must be a power of two, at least 8.
- RADDR, 3, destination register index width.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept an op this cycle.
- in_op  in  4  operation code, encoding below.
- in_a  in  WIDTH  operand A (Rs).
- in_b  in  WIDTH  operand B (Rt or extended immediate, already selected upstream).
- in_imm  in  WIDTH  sign-extended displacement for branch/JR.
- in_pc_plus  in  WIDTH  PC of next sequential instruction.
- in_dst  in  RADDR  destination register index.
- in_wen  in  1  op writes a register.
- flush  in  1  synchronous kill of in-flight and held work.
- out_valid  out  1  result register holds a valid op.
- out_ready  in  1  downstream accepts the result.
- out_result  out  WIDTH  result value.
- out_dst  out  RADDR  registered in_dst.
- out_wen  out  1  registered write enable; forced 0 for branches.
- out_ovf  out  1  signed overflow, ADD/SUB only.
- redirect_valid  out  1  one-cycle pulse: taken branch or JR.
- redirect_pc  out  WIDTH  target PC; valid while redirect_valid is high.

Behaviour:
- Op encoding:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 XOR.
  - 4 SLL, 5 SRL, 6 ROL: shift a by b[SHW-1:0].
  - 7 SEQ: result (a==b). 8 SLT: signed (a<b). Both give 0 or 1, zero-extended.
  - 9 MUL: low WIDTH bits of a*b, unsigned, multi-cycle.
  - 10 BEQZ, 11 BNEZ, 12 BLTZ, 13 BGEZ: test a (signed).
  - 14 JR: result = in_pc_plus (link).
  - 15 reserved: treated as ADD with out_wen=0.
- All arithmetic wraps modulo 2^WIDTH. out_ovf follows two's-complement rules and is 0 for all other ops.
- Branch target is in_pc_plus+in_imm; JR target is in_a+in_imm; both wrap. Untaken branches produce no redirect.
- Branches set out_result to 0.
- Reset: state=IDLE; out_valid, redirect_valid, out_wen and out_ovf are 0; out_result, out_dst and redirect_pc are 0; multiplier registers are cleared.
- States:
  - IDLE: in_ready = !flush && (!out_valid || out_ready).
    - Accept of a non-MUL op: at that edge, register the result; out_valid=1.
    - Accept of a branch/JR: redirect_valid=1 for exactly one cycle, even if out_ready is low. redirect_pc is registered on the same edge.
    - Accept of MUL: go to MUL_BUSY; load multiplicand, multiplier and a bit counter (WIDTH); out_valid drops if the held result was consumed on that edge.
  - MUL_BUSY: in_ready=0. One shift-add step per cycle; the counter decrements. After WIDTH steps, go to MUL_DONE.
  - MUL_DONE: load out_result when !out_valid || out_ready; set out_valid=1; go to IDLE.
- MUL latency: out_valid rises at edge accept+WIDTH+1 when unstalled.
- Holding register: out_* remain stable while out_valid && !out_ready.
- Back-to-back throughput: one non-MUL op per cycle when out_ready is held high.
- flush (synchronous, highest priority):
  - At the edge: out_valid=0, redirect_valid=0, state=IDLE; any MUL is aborted and its result discarded.
  - An op presented with in_valid during the flush cycle is not accepted (in_ready=0).
- Simultaneous out_ready and accept in the same cycle: the old result retires and the new one loads on the same edge.
- rst_n asserted mid-MUL: immediate return to reset values; no result is produced.
- Shift amount 0 returns a unchanged. ROL by WIDTH-1 is valid.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, redirect_valid=0, in_ready=1 after release.
- Overflow: WIDTH=16, ADD 0x7FFF+0x0001, out_ready=1 -> out_result=0x8000, out_ovf=1, one cycle latency. SUB 0x0000-0x0001 -> 0xFFFF, out_ovf=0.
- Branch: BLTZ a=0xFFF0, pc_plus=0x0010, imm=0xFFFA -> redirect_valid pulse of exactly one cycle, redirect_pc=0x000A, out_wen=0. BGEZ with the same a -> no redirect.
- Multiply: MUL 0x0123*0x0045 -> out_result=0x4E6F at accept+17 cycles, in_ready=0 throughout. With out_ready=0 at completion, the result is held until out_ready=1.
- Flush: flush asserted 5 cycles into a MUL -> out_valid never rises for it. The next ADD 2+3 accepted after the flush -> 5.
- Streaming: 8 back-to-back ADDs with out_ready toggling 1,0,1,0 -> no op lost or duplicated, order preserved. Also test WIDTH=32: ROL 0x80000001 by 1 -> 0x00000003.

Source files
------------

// File: rtl/ex_stage_pipe.sv
// Pipelined execute stage: ALU, branch/JR resolution with a registered redirect pulse,
// an iterative shift-add multiplier, and an EX/MEM holding register with valid/ready flow.
module ex_stage_pipe #(
  parameter int WIDTH = 16,
  parameter int RADDR = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc_plus,
  input  logic [RADDR-1:0] in_dst,
  input  logic             in_wen,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RADDR-1:0] out_dst,
  output logic             out_wen,
  output logic             out_ovf,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_SEQ  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_BEQZ = 4'd10;
  localparam logic [3:0] OP_BNEZ = 4'd11;
  localparam logic [3:0] OP_BLTZ = 4'd12;
  localparam logic [3:0] OP_BGEZ = 4'd13;
  localparam logic [3:0] OP_JR   = 4'd14;

  // Two's-complement overflow from operand and result sign bits; SUB passes ~b's sign.
  function automatic logic ovf_add(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  logic [1:0]             state;
  logic [WIDTH-1:0]       mcand, mplier, acc;
  logic [SHW:0]           cnt;
  logic [RADDR-1:0]       mul_dst;
  logic                   mul_wen;

  logic                   accept, mul_ld;
  logic signed [WIDTH-1:0] sa, sb;
  logic [SHW-1:0]         shamt;
  logic [SHW:0]           rsh;
  logic [WIDTH-1:0]       sum, diff, res_c, tgt_c;
  logic                   ovf_c, wen_c, redir_c;

  assign in_ready = (state == S_IDLE) && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_ld   = (state == S_DONE) && (!out_valid || out_ready);

  always_comb begin
    sa      = in_a;
    sb      = in_b;
    shamt   = in_b[SHW-1:0];
    rsh     = (SHW+1)'(WIDTH) - {1'b0, shamt};
    sum     = in_a + in_b;
    diff    = in_a - in_b;
    res_c   = '0;
    ovf_c   = 1'b0;
    wen_c   = in_wen;
    redir_c = 1'b0;
    tgt_c   = in_pc_plus + in_imm;
    case (in_op)
      OP_ADD: begin
        res_c = sum;
        ovf_c = ovf_add(in_a[WIDTH-1], in_b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff;
        ovf_c = ovf_add(in_a[WIDTH-1], ~in_b[WIDTH-1], diff[WIDTH-1]);
      end
      OP_AND:  res_c = in_a & in_b;
      OP_XOR:  res_c = in_a ^ in_b;
      OP_SLL:  res_c = in_a << shamt;
      OP_SRL:  res_c = in_a >> shamt;
      // A shift of WIDTH yields zero, so rotate by 0 returns a unchanged.
      OP_ROL:  res_c = (in_a << shamt) | (in_a >> rsh);
      OP_SEQ:  res_c = {{(WIDTH-1){1'b0}}, in_a == in_b};
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, sa < sb};
      OP_MUL:  res_c = '0;
      OP_BEQZ: begin wen_c = 1'b0; redir_c = (in_a == '0);    end
      OP_BNEZ: begin wen_c = 1'b0; redir_c = (in_a != '0);    end
      OP_BLTZ: begin wen_c = 1'b0; redir_c = in_a[WIDTH-1];   end
      OP_BGEZ: begin wen_c = 1'b0; redir_c = !in_a[WIDTH-1];  end
      OP_JR: begin
        res_c   = in_pc_plus;
        redir_c = 1'b1;
        tgt_c   = in_a + in_imm;
      end
      default: begin
        res_c = sum;
        wen_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_dst        <= '0;
      out_wen        <= 1'b0;
      out_ovf        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      cnt            <= '0;
      mul_dst        <= '0;
      mul_wen        <= 1'b0;
    end else if (flush) begin
      state          <= S_IDLE;
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && in_op == OP_MUL) begin
            state   <= S_BUSY;
            mcand   <= in_a;
            mplier  <= in_b;
            acc     <= '0;
            cnt     <= (SHW+1)'(WIDTH);
            mul_dst <= in_dst;
            mul_wen <= in_wen;
          end else if (accept) begin
            out_valid      <= 1'b1;
            out_result     <= res_c;
            out_dst        <= in_dst;
            out_wen        <= wen_c;
            out_ovf        <= ovf_c;
            redirect_valid <= redir_c;
            if (redir_c) redirect_pc <= tgt_c;
          end
        end
        // One shift-add step per cycle, LSB of the multiplier first.
        S_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - (SHW+1)'(1);
          if (cnt == (SHW+1)'(1)) state <= S_DONE;
        end
        S_DONE: begin
          if (mul_ld) begin
            out_valid  <= 1'b1;
            out_result <= acc;
            out_dst    <= mul_dst;
            out_wen    <= mul_wen;
            out_ovf    <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: a 16-bit instance for most scenarios, a 32-bit one for ROL.
module tb_ex_stage_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_wen, flush, out_valid, out_ready, out_wen, out_ovf, redirect_valid;
  logic [3:0]  in_op;
  logic [15:0] in_a, in_b, in_imm, in_pc_plus, out_result, redirect_pc;
  logic [2:0]  in_dst, out_dst;

  logic        w_in_valid, w_in_ready, w_in_wen, w_flush, w_out_valid, w_out_ready, w_out_wen, w_out_ovf, w_redirect_valid;
  logic [3:0]  w_in_op;
  logic [31:0] w_in_a, w_in_b, w_in_imm, w_in_pc_plus, w_out_result, w_redirect_pc;
  logic [2:0]  w_in_dst, w_out_dst;

  int checks = 0;
  int errors = 0;

  ex_stage_pipe #(.WIDTH(16), .RADDR(3)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_pc_plus(in_pc_plus), .in_dst(in_dst),
    .in_wen(in_wen), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dst(out_dst), .out_wen(out_wen), .out_ovf(out_ovf),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  ex_stage_pipe #(.WIDTH(32), .RADDR(3)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op),
    .in_a(w_in_a), .in_b(w_in_b), .in_imm(w_in_imm), .in_pc_plus(w_in_pc_plus), .in_dst(w_in_dst),
    .in_wen(w_in_wen), .flush(w_flush), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_result(w_out_result), .out_dst(w_out_dst), .out_wen(w_out_wen), .out_ovf(w_out_ovf),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] dst, input logic wen);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_dst   = dst;
    in_wen   = wen;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) begin
      in_valid = 1'($urandom); in_op = 4'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
      in_imm = 16'($urandom); in_pc_plus = 16'($urandom); in_dst = 3'($urandom);
      in_wen = 1'($urandom); flush = 1'($urandom); out_ready = 1'($urandom);
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids got out_valid=%b redirect_valid=%b want 0 0", out_valid, redirect_valid);
    end
    checks++;
    if (out_result !== 16'h0 || out_wen !== 1'b0 || out_ovf !== 1'b0 || redirect_pc !== 16'h0 || out_dst !== 3'd0) begin
      errors++; $display("FAIL reset_data got result=%h wen=%b ovf=%b rpc=%h dst=%0d want zeros",
                         out_result, out_wen, out_ovf, redirect_pc, out_dst);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_imm = '0; in_pc_plus = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release got in_ready=%b out_valid=%b w_in_ready=%b want 1 0 1",
                         in_ready, out_valid, w_in_ready);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    drive(4'd0, 16'h7FFF, 16'h0001, 3'd3, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h8000 || out_ovf !== 1'b1 || out_dst !== 3'd3 || out_wen !== 1'b1) begin
      errors++; $display("FAIL add_ovf got v=%b res=%h ovf=%b dst=%0d wen=%b want 1 8000 1 3 1",
                         out_valid, out_result, out_ovf, out_dst, out_wen);
    end
    drive(4'd1, 16'h0000, 16'h0001, 3'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'hFFFF || out_ovf !== 1'b0 || out_dst !== 3'd4) begin
      errors++; $display("FAIL sub_wrap got v=%b res=%h ovf=%b dst=%0d want 1 ffff 0 4",
                         out_valid, out_result, out_ovf, out_dst);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL retire_drop got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_branch();
    out_ready = 1'b0;
    in_imm = 16'hFFFA; in_pc_plus = 16'h0010;
    drive(4'd12, 16'hFFF0, 16'h0000, 3'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 16'h000A || out_wen !== 1'b0 || out_result !== 16'h0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bltz_taken got rv=%b rpc=%h wen=%b res=%h v=%b want 1 000a 0 0000 1",
                         redirect_valid, redirect_pc, out_wen, out_result, out_valid);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL redirect_pulse got rv=%b v=%b want 0 1", redirect_valid, out_valid);
    end
    out_ready = 1'b1;
    drive(4'd13, 16'hFFF0, 16'h0000, 3'd5, 1'b1);
    tick();
    checks++;
    if (redirect_valid !== 1'b0 || out_valid !== 1'b1 || out_wen !== 1'b0) begin
      errors++; $display("FAIL bgez_untaken got rv=%b v=%b wen=%b want 0 1 0", redirect_valid, out_valid, out_wen);
    end
    in_imm = 16'h0004; in_pc_plus = 16'h0022;
    drive(4'd14, 16'h0100, 16'h0000, 3'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0104 || out_result !== 16'h0022 || out_wen !== 1'b1 || out_dst !== 3'd7) begin
      errors++; $display("FAIL jr_link got rv=%b rpc=%h res=%h wen=%b dst=%0d want 1 0104 0022 1 7",
                         redirect_valid, redirect_pc, out_result, out_wen, out_dst);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL jr_after got rv=%b v=%b want 0 0", redirect_valid, out_valid);
    end
    in_imm = '0; in_pc_plus = '0;
  endtask

  task automatic test_mul();
    logic bad;
    out_ready = 1'b1;
    drive(4'd9, 16'h0123, 16'h0045, 3'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    bad = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL mul_busy got early valid or ready=%b want 0", bad);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h4E6F || out_dst !== 3'd2 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL mul_result got v=%b res=%h dst=%0d ovf=%b want 1 4e6f 2 0",
                         out_valid, out_result, out_dst, out_ovf);
    end
    drive(4'd9, 16'h0003, 16'h0005, 3'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mul_consume got v=%b want 0", out_valid);
    end
    repeat (17) tick();
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h000F || out_dst !== 3'd1) begin
      errors++; $display("FAIL mul_hold got v=%b res=%h dst=%0d want 1 000f 1", out_valid, out_result, out_dst);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mul_release got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    logic bad;
    out_ready = 1'b1;
    drive(4'd9, 16'h0007, 16'h0009, 3'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    drive(4'd0, 16'h0002, 16'h0003, 3'd6, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got in_ready=%b want 0", in_ready);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle got in_ready=%b v=%b want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h0005 || out_dst !== 3'd6) begin
      errors++; $display("FAIL flush_add got v=%b res=%h dst=%0d want 1 0005 6", out_valid, out_result, out_dst);
    end
    tick();
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL flush_abort got late valid=%b want 0", bad);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  ops  [8] = '{4'd4, 4'd5, 4'd6, 4'd8, 4'd7, 4'd3, 4'd2, 4'd15};
    logic [15:0] av   [8] = '{16'h0003, 16'h8000, 16'h8001, 16'hFFFF, 16'h1234, 16'hF0F0, 16'hF0F0, 16'h0005};
    logic [15:0] bv   [8] = '{16'h0000, 16'h0004, 16'h000F, 16'h0001, 16'h1234, 16'h0FF0, 16'h0FF0, 16'h0006};
    logic [15:0] expv [8] = '{16'h0003, 16'h0800, 16'hC000, 16'h0001, 16'h0001, 16'hFF00, 16'h00F0, 16'h000B};
    logic        ewen [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], av[i], bv[i], 3'(i), 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== expv[i] || out_wen !== ewen[i]) begin
        errors++; $display("FAIL alu_op%0d got v=%b res=%h wen=%b want 1 %h %b",
                           ops[i], out_valid, out_result, out_wen, expv[i], ewen[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int rcv  = 0;
    logic [15:0] exp_res;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      out_ready = (cyc % 2 == 0);
      if (sent < 8) drive(4'd0, 16'(sent * 16), 16'(sent + 3), 3'(sent), 1'b1);
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        exp_res = 16'(rcv * 17 + 3);
        checks++;
        if (out_result !== exp_res || out_dst !== 3'(rcv)) begin
          errors++; $display("FAIL stream_item%0d got res=%h dst=%0d want %h %0d",
                             rcv, out_result, out_dst, exp_res, rcv);
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    checks++;
    if (rcv != 8 || sent != 8) begin
      errors++; $display("FAIL stream_count got sent=%0d rcv=%0d want 8 8", sent, rcv);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_extra got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_rol32();
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_op = 4'd6; w_in_a = 32'h80000001; w_in_b = 32'h1; w_in_dst = 3'd2; w_in_wen = 1'b1;
    tick();
    w_in_valid = 1'b0;
    checks++;
    if (w_out_valid !== 1'b1 || w_out_result !== 32'h00000003) begin
      errors++; $display("FAIL rol32 got v=%b res=%h want 1 00000003", w_out_valid, w_out_result);
    end
  endtask

  initial begin
    w_in_valid = 1'b0; w_in_op = '0; w_in_a = '0; w_in_b = '0; w_in_imm = '0; w_in_pc_plus = '0;
    w_in_dst = '0; w_in_wen = 1'b0; w_flush = 1'b0; w_out_ready = 1'b1;
    test_reset();
    test_overflow();
    test_branch();
    test_mul();
    test_flush();
    test_alu();
    test_back_to_back();
    test_rol32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
